// File: rtl/resync_replay_engine.sv
// resync_replay_engine
//   Replays trail entries [start_idx, trail_height) to the PSE/VDE resync ports.
//   On start: one-cycle clear_shadows/fifo_flush pulse, then reads are issued to
//   the trail RAM (latency RD_LAT), returns flow through a valid shift pipeline
//   into a skid FIFO whose head drives a valid/ready stream. Reads are credit
//   limited so the FIFO can never overflow. A replay may be aborted.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   start/abort                 control from the solver core FSM
//   start_idx/trail_height      replay range, latched on accepted start
//   busy/done/done_aborted      status; done is a one-cycle pulse
//   clear_shadows/fifo_flush    one-cycle pulses at the start of a replay
//   trail_rd_en/idx, trail_rd_var/value   trail RAM read port
//   resync_valid/ready/var/value/last     output stream
//
// Optional feature: define RESYNC_STATS_EN to add stat_cycles / stat_stalls.
module resync_replay_engine #(
  parameter int VAR_W      = 32,
  parameter int IDX_W      = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] start_idx,
  input  logic [IDX_W-1:0] trail_height,
  output logic             busy,
  output logic             done,
  output logic             done_aborted,
  output logic             clear_shadows,
  output logic             fifo_flush,
  output logic             trail_rd_en,
  output logic [IDX_W-1:0] trail_rd_idx,
  input  logic [VAR_W-1:0] trail_rd_var,
  input  logic             trail_rd_value,
  output logic             resync_valid,
  input  logic             resync_ready,
  output logic [VAR_W-1:0] resync_var,
  output logic             resync_value,
  output logic             resync_last
`ifdef RESYNC_STATS_EN
  ,
  output logic [31:0]      stat_cycles,
  output logic [31:0]      stat_stalls
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, REPLAY, DONE} state_t;

  typedef struct packed {
    logic [VAR_W-1:0] data;
    logic             value;
    logic             last;
  } entry_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] rd_ptr, end_ptr;
  logic             empty_q, aborted_q;
  logic [CNT_W-1:0] used;      // reads in flight + FIFO occupancy
  logic [CNT_W-1:0] cnt;       // FIFO occupancy
  logic [PTR_W-1:0] wr_ptr, hd_ptr;
  entry_t           mem [FIFO_DEPTH];
  entry_t           head;

  logic rd_en, rd_last, ret_vld, ret_last, push, pop, abort_take, kill;

  assign abort_take = abort && (state_q == CLEAR || state_q == REPLAY);
  // CLEAR and abort both empty the FIFO and drop anything still in flight.
  assign kill       = (state_q == CLEAR) || abort_take;

  assign rd_en   = (state_q == REPLAY) && !abort && (rd_ptr < end_ptr) &&
                   (used < CNT_W'(FIFO_DEPTH));
  assign rd_last = (rd_ptr == end_ptr - IDX_W'(1));

  // Return path: valid/last travel alongside the RAM access, data is taken
  // straight from the RAM port when the valid reaches the end.
  generate
    if (RD_LAT == 0) begin : g_lat0
      assign ret_vld  = rd_en;
      assign ret_last = rd_last;
    end else begin : g_lat
      logic [RD_LAT:1] vld_pipe, last_pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe  <= '0;
          last_pipe <= '0;
        end else if (kill) begin
          vld_pipe  <= '0;
          last_pipe <= '0;
        end else begin
          vld_pipe[1]  <= rd_en;
          last_pipe[1] <= rd_last;
          for (int k = 2; k <= RD_LAT; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1];
            last_pipe[k] <= last_pipe[k-1];
          end
        end
      end
      assign ret_vld  = vld_pipe[RD_LAT];
      assign ret_last = last_pipe[RD_LAT];
    end
  endgenerate

  assign push = ret_vld && (state_q == REPLAY) && !abort;
  assign head = mem[hd_ptr];

  assign resync_valid = (cnt != '0);
  assign pop          = resync_valid && resync_ready;
  assign resync_var   = resync_valid ? head.data  : '0;
  assign resync_value = resync_valid && head.value;
  assign resync_last  = resync_valid && head.last;

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign done_aborted  = (state_q == DONE) && aborted_q;
  assign clear_shadows = (state_q == CLEAR);
  assign fifo_flush    = (state_q == CLEAR);
  assign trail_rd_en   = rd_en;
  assign trail_rd_idx  = rd_en ? rd_ptr : '0;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR:  state_d = abort ? DONE : REPLAY;
      REPLAY: if (abort || empty_q || (pop && head.last)) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Range pointers and replay flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      end_ptr   <= '0;
      empty_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        rd_ptr    <= start_idx;
        end_ptr   <= trail_height;
        empty_q   <= !(start_idx < trail_height);
        aborted_q <= 1'b0;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + IDX_W'(1);
      end
      if (abort_take) aborted_q <= 1'b1;
    end
  end

  // Credit counter and FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used   <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      hd_ptr <= '0;
    end else if (kill) begin
      used   <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      hd_ptr <= '0;
    end else begin
      used <= used + CNT_W'(rd_en) - CNT_W'(pop);
      cnt  <= cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  hd_ptr <= hd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: the outputs are masked by resync_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: trail_rd_var, value: trail_rd_value, last: ret_last};
  end

`ifdef RESYNC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cycles <= '0;
      stat_stalls <= '0;
    end else if (state_q == IDLE && start) begin
      stat_cycles <= '0;
      stat_stalls <= '0;
    end else begin
      if (busy && stat_cycles != '1) stat_cycles <= stat_cycles + 32'd1;
      if (resync_valid && !resync_ready && stat_stalls != '1)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_resync_replay_engine.sv
// Directed bench for resync_replay_engine: u1 uses RD_LAT=1, u2 uses RD_LAT=2.
module tb_resync_replay_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0, abort = 1'b0, ready = 1'b1;
  logic [15:0] start_idx = '0, height = '0;

  logic        busy1, done1, dab1, clr1, fl1, rd_en1, vld1, val1, last1;
  logic [15:0] rd_idx1;
  logic [31:0] var1, d1_var;
  logic        d1_val;
  logic        busy2, done2, dab2, clr2, fl2, rd_en2, vld2, val2, last2;
  logic [15:0] rd_idx2, a2;
  logic [31:0] var2, d2_var;
  logic        d2_val;
`ifdef RESYNC_STATS_EN
  logic [31:0] sc1, ss1, sc2, ss2;
`endif

  int checks = 0, errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fvar(input logic [15:0] i);
    return {16'hBEEF, i};
  endfunction
  function automatic logic fval(input logic [15:0] i);
    return ^i;
  endfunction

  // Trail RAM models
  always @(posedge clk) begin
    d1_var <= fvar(rd_idx1);
    d1_val <= fval(rd_idx1);
    a2     <= rd_idx2;
    d2_var <= fvar(a2);
    d2_val <= fval(a2);
  end

  resync_replay_engine #(.VAR_W(32), .IDX_W(16), .RD_LAT(1), .FIFO_DEPTH(4)) u1 (
`ifdef RESYNC_STATS_EN
    .stat_cycles(sc1), .stat_stalls(ss1),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_idx(start_idx), .trail_height(height),
    .busy(busy1), .done(done1), .done_aborted(dab1),
    .clear_shadows(clr1), .fifo_flush(fl1),
    .trail_rd_en(rd_en1), .trail_rd_idx(rd_idx1),
    .trail_rd_var(d1_var), .trail_rd_value(d1_val),
    .resync_valid(vld1), .resync_ready(ready),
    .resync_var(var1), .resync_value(val1), .resync_last(last1));

  resync_replay_engine #(.VAR_W(32), .IDX_W(16), .RD_LAT(2), .FIFO_DEPTH(4)) u2 (
`ifdef RESYNC_STATS_EN
    .stat_cycles(sc2), .stat_stalls(ss2),
`endif
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
    .start_idx(start_idx), .trail_height(height),
    .busy(busy2), .done(done2), .done_aborted(dab2),
    .clear_shadows(clr2), .fifo_flush(fl2),
    .trail_rd_en(rd_en2), .trail_rd_idx(rd_idx2),
    .trail_rd_var(d2_var), .trail_rd_value(d2_val),
    .resync_valid(vld2), .resync_ready(ready),
    .resync_var(var2), .resync_value(val2), .resync_last(last2));

  // Observations, sampled at negedge; cycle numbers are relative to the start cycle.
  int t0 = 0, rel, rd_cnt, hs_cnt, max_out, vcnt, done_cnt, clr_cyc, done_cyc;
  int stall_viol, stalls, bad_flush, outst;
  logic        done_ab, prev_stall;
  logic [31:0] prev_var;
  logic        prev_last;
  logic [31:0] hs_var [64];
  logic        hs_val [64];
  logic        hs_last[64];
  int          hs_cyc [64];

  int t2 = 0, rel2, hs2_cnt, rd2_cnt, rd2_max, fv2, done2_cyc;
  logic [31:0] hs2_var[16];

  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy1) begin
        t0 = cyc; rd_cnt = 0; hs_cnt = 0; max_out = 0; vcnt = 0; done_cnt = 0;
        clr_cyc = -1; done_cyc = -1; stall_viol = 0; stalls = 0; bad_flush = 0;
        done_ab = 1'b0; prev_stall = 1'b0;
      end
      rel = cyc - t0;
      if (rd_en1) begin
        rd_cnt++;
        outst = rd_cnt - hs_cnt;
        if (outst > max_out) max_out = outst;
      end
      if (clr1) clr_cyc = rel;
      if (clr1 !== fl1) bad_flush++;
      if (vld1) vcnt++;
      if (prev_stall && (!vld1 || var1 !== prev_var || last1 !== prev_last)) stall_viol++;
      prev_stall = vld1 && !ready && !abort;
      prev_var   = var1;
      prev_last  = last1;
      if (vld1 && !ready) stalls++;
      if (vld1 && ready && hs_cnt < 64) begin
        hs_var[hs_cnt] = var1; hs_val[hs_cnt] = val1; hs_last[hs_cnt] = last1;
        hs_cyc[hs_cnt] = rel; hs_cnt++;
      end
      if (done1) begin done_cnt++; done_cyc = rel; done_ab = dab1; end

      if (start2 && !busy2) begin
        t2 = cyc; hs2_cnt = 0; rd2_cnt = 0; rd2_max = 0; fv2 = -1; done2_cyc = -1;
      end
      rel2 = cyc - t2;
      if (rd_en2) begin
        rd2_cnt++;
        if (int'(rd_idx2) > rd2_max) rd2_max = int'(rd_idx2);
      end
      if (vld2 && fv2 < 0) fv2 = rel2;
      if (vld2 && ready && hs2_cnt < 16) begin hs2_var[hs2_cnt] = var2; hs2_cnt++; end
      if (done2) done2_cyc = rel2;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic kick(input logic [15:0] s, input logic [15:0] h);
    start_idx = s; height = h; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [63:0] outs1();
    return {7'd0, busy1, done1, dab1, clr1, fl1, rd_en1, vld1, last1, rd_idx1, var1, val1};
  endfunction

  initial begin
    int bad;
    logic got;

    // Reset state
    step(); step();
    check("reset_outputs", outs1(), 64'd0);
    rst_n = 1'b1;
    step();
    check("idle_busy", {63'd0, busy1}, 64'd0);

    // Full-rate replay, RD_LAT=1, 0..4
    ready = 1'b1;
    kick(16'd0, 16'd5);
    repeat (12) step();
    check("full_clear_cycle", clr_cyc, 1);
    check("full_flush_coincident", bad_flush, 0);
    check("full_hs_count", hs_cnt, 5);
    check("full_first_hs_cycle", hs_cyc[0], 4);
    check("full_last_hs_cycle", hs_cyc[4], 8);
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (hs_var[i] !== fvar(16'(i)) || hs_val[i] !== fval(16'(i)) ||
          hs_last[i] !== (i == 4)) bad++;
    check("full_data_order_last", bad, 0);
    check("full_done_cycle", done_cyc, 9);
    check("full_done_aborted", {63'd0, done_ab}, 64'd0);
    check("full_done_count", done_cnt, 1);

    // Partial range, RD_LAT=2, 3..5
    start_idx = 16'd3; height = 16'd6; start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (12) step();
    check("part_hs_count", hs2_cnt, 3);
    bad = 0;
    for (int i = 0; i < 3; i++) if (hs2_var[i] !== fvar(16'(i + 3))) bad++;
    check("part_data_order", bad, 0);
    check("part_read_count", rd2_cnt, 3);
    check("part_max_read_idx", rd2_max, 5);
    check("part_first_valid_cycle", fv2, 5);
    check("part_done_cycle", done2_cyc, 8);

    // Empty range
    kick(16'd7, 16'd7);
    repeat (6) step();
    check("empty_clear_cycle", clr_cyc, 1);
    check("empty_done_cycle", done_cyc, 3);
    check("empty_reads", rd_cnt, 0);
    check("empty_valids", vcnt, 0);

    // Backpressure: ready 1,0,0,1
    kick(16'd0, 16'd16);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      ready = (i % 4 == 1 || i % 4 == 2) ? 1'b0 : 1'b1;
      step();
      got = (done_cnt != 0);
    end
    ready = 1'b1;
    check("bp_done_seen", {63'd0, got}, 64'd1);
    check("bp_hs_count", hs_cnt, 16);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (hs_var[i] !== fvar(16'(i)) || hs_last[i] !== (i == 15)) bad++;
    check("bp_data_order", bad, 0);
    check("bp_stable_while_stalled", stall_viol, 0);
    check("bp_credit_limit", {63'd0, max_out <= 4}, 64'd1);
    check("bp_saw_stalls", {63'd0, stalls > 0}, 64'd1);
`ifdef RESYNC_STATS_EN
    check("stat_stalls", ss1, stalls);
    check("stat_cycles", sc1, done_cyc);
`endif

    // Abort after 4 handshakes
    step();
    kick(16'd0, 16'd10);
    for (int i = 0; i < 50 && hs_cnt < 4; i++) step();
    check("abort_reached_4", hs_cnt, 4);
    abort = 1'b1; ready = 1'b0;
    step();
    abort = 1'b0; ready = 1'b1;
    check("abort_valid_dropped", {63'd0, vld1}, 64'd0);
    check("abort_done", {62'd0, done1, dab1}, 64'd3);
    repeat (10) step();
    check("abort_no_more_hs", hs_cnt, 4);
    check("abort_valid_cycles", vcnt, 5);
    check("abort_done_count", done_cnt, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) if (hs_var[i] !== fvar(16'(i))) bad++;
    check("abort_data", bad, 0);

    // Clean replay after abort
    kick(16'd2, 16'd5);
    repeat (12) step();
    check("restart_hs_count", hs_cnt, 3);
    bad = 0;
    for (int i = 0; i < 3; i++) if (hs_var[i] !== fvar(16'(i + 2))) bad++;
    check("restart_data", bad, 0);
    check("restart_not_aborted", {63'd0, done_ab}, 64'd0);

    // Reset mid-replay
    kick(16'd0, 16'd16);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", outs1(), 64'd0);
    repeat (3) step();
    check("midreset_no_done", done_cnt, 0);
    rst_n = 1'b1;
    step();
    check("after_reset_idle", {62'd0, busy1, vld1}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/resync_replay_engine.md
# resync_replay_engine

Parametrised trail replay engine; successor to the single-rate resync controller. On `start` it pulses the shadow/FIFO clears, then replays trail entries `[start_idx, trail_height)` to the PSE/VDE. The trail RAM read latency is configurable, and the output is a valid/ready stream with backpressure and a skid FIFO. A replay can be aborted. The block sits between the Trail Manager and the PSE/VDE resync ports and is driven by the solver core FSM.

## Interface
- `VAR_W`, 32, variable index width
- `IDX_W`, 16, trail index width
- `RD_LAT`, 1, trail read latency in cycles, legal 0..3
- `FIFO_DEPTH`, 4, skid FIFO entries, power of 2, >= `RD_LAT`+2
- `clk`  in  1  clock
- `rst_n`  in  1  reset rst_n, asynchronous, active-low
- `start`  in  1  begin replay; sampled only in IDLE
- `abort`  in  1  cancel replay; ignored in IDLE
- `start_idx`  in  IDX_W  first trail index to replay; latched on accepted start
- `trail_height`  in  IDX_W  end index, exclusive; latched on accepted start
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `done_aborted`  out  1  qualifies `done`: replay was aborted
- `clear_shadows`  out  1  one-cycle pulse
- `fifo_flush`  out  1  one-cycle pulse, coincident with `clear_shadows`
- `trail_rd_en`  out  1  trail read request
- `trail_rd_idx`  out  IDX_W  trail read address
- `trail_rd_var`  in  VAR_W  read data, valid `RD_LAT` cycles after `trail_rd_en`
- `trail_rd_value`  in  1  read data, same timing as `trail_rd_var`
- `resync_valid`  out  1  output entry valid
- `resync_ready`  in  1  consumer accepts entry
- `resync_var`  out  VAR_W  replayed variable
- `resync_value`  out  1  replayed value
- `resync_last`  out  1  marks the final entry of this replay

## Operation
- **States:** IDLE → CLEAR → REPLAY → DONE → IDLE.
- **IDLE:**
  - On `start`, latch `start_idx` into rd_ptr and `trail_height` into end_ptr. Go to CLEAR.
  - `start` while `busy` is ignored.
- **CLEAR:** assert `clear_shadows` and `fifo_flush` for one cycle. Go to REPLAY.
- **REPLAY, reads:**
  - Issue `trail_rd_en` with `trail_rd_idx`=rd_ptr while rd_ptr < end_ptr and credits are available. Increment rd_ptr on each read.
  - Credits available means (in-flight reads + FIFO occupancy) < `FIFO_DEPTH`. The FIFO therefore never overflows and data is never dropped.
- **REPLAY, return path:**
  - Returned data is pushed into the FIFO through an `RD_LAT`-deep valid shift pipeline.
  - The pipeline also carries a last flag, set for index end_ptr-1.
- **REPLAY, output:**
  - The FIFO head drives `resync_var`, `resync_value` and `resync_last`.
  - An entry transfers when `resync_valid`&&`resync_ready`.
  - Once `resync_valid` rises, it and the data are held stable until the handshake.
  - Entries leave in trail order.
- **REPLAY, exit:** go to DONE after the handshake of the last entry.
- **Empty range:** if the latched `start_idx` >= `trail_height`, the block issues no reads and no `resync_valid`, and goes from REPLAY to DONE in one cycle.
- **DONE:** pulse `done`. Go to IDLE.
- **Abort:**
  - `abort` in CLEAR or REPLAY discards the FIFO and in-flight returns (later return data is ignored), drops `resync_valid` the next cycle, and goes to DONE with `done_aborted`=1.
  - If `abort` coincides with the last handshake, that handshake completes and `done_aborted`=1.
  - `abort` in DONE has no effect.
- **Arithmetic:** rd_ptr is `IDX_W` bits and compared unsigned; it never wraps because it stops at end_ptr. The occupancy and credit counters are sized for `FIFO_DEPTH`.

## Timing
- **Reset:**
  - All outputs are 0: `busy`, `done`, `done_aborted`, `clear_shadows`, `fifo_flush`, `trail_rd_en`, `resync_valid`, `resync_last`, `trail_rd_idx`, `resync_var`, `resync_value`.
  - State is IDLE; the FIFO and pipeline are empty.
  - Reset mid-replay takes effect immediately, with no `done`.
- **Start sequence:**
  - `start` in cycle 0 gives `busy` and `clear_shadows` in cycle 1.
  - First `trail_rd_en` is in cycle 2.
  - First `resync_valid` is in cycle 3+`RD_LAT`; the FIFO output is registered.
- **Throughput:** with `resync_ready` held high, one entry per cycle.
- **Total latency:** N entries complete their last handshake in cycle N+2+`RD_LAT`; `done` follows one cycle later.
- **Empty range:** `done` at cycle 3.
- **Stalls:** with `resync_ready` low, reads stop after the credits are exhausted. They resume the cycle after a handshake frees a credit.

## Configuration
- **`RESYNC_STATS_EN`:**
  - Defined: adds outputs `stat_cycles` (32b, cycles spent busy in the last replay) and `stat_stalls` (32b, cycles with `resync_valid`&&!`resync_ready`).
  - Both counters clear on accepted start, saturate at all-ones, and hold their value in IDLE.
  - Not defined: neither the ports nor the counters exist.

## Test plan
- **Full-rate replay:** `RD_LAT`=1, start_idx=0, height=5, ready=1 → `clear_shadows`/`fifo_flush` at cycle 1; vars of idx 0..4 on cycles 4..8; `resync_last` on idx 4; `done` at cycle 9, `done_aborted`=0.
- **Partial range:** start_idx=3, height=6, `RD_LAT`=2 → exactly idx 3,4,5 emitted in order; no read of idx 6.
- **Empty range:** start_idx=7, height=7 → pulses at cycle 1, `done` at cycle 3, zero `trail_rd_en` and zero `resync_valid`.
- **Backpressure:** height=16, ready toggles 1,0,0,1 → all 16 entries delivered in order, no duplicates; data stable while stalled; outstanding+occupancy never exceeds 4.
- **Abort:** height=10, abort after 4 handshakes → `resync_valid` low the next cycle, `done`+`done_aborted`=1, no further handshakes; late returns ignored; next start replays cleanly.
- **Stats (`RESYNC_STATS_EN`) and reset:** `stat_stalls` equals the count of ready-low cycles while valid. `rst_n` low mid-replay → all outputs 0 immediately, no `done`.
